// File: rtl/ifu_fetch.sv
// Instruction fetch unit: architectural PC, req/ack fetch FSM and instruction register.
// Optional IFU_ALIGN_CHECK_EN: reject misaligned PC commits and raise sticky misalign.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_start,
  input  logic        pc_wr,
  input  logic [31:0] npc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic [31:0] pc,
  output logic [31:0] npc_t,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic        busy,
  output logic        misalign
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state, state_nxt;

  logic        pend_valid;
  logic [31:0] pend_npc;
  logic        commit;
  logic [31:0] commit_val;
  logic        commit_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fetch_start) state_nxt = REQ;
      REQ:     if (im_ack) state_nxt = DONE;
      DONE:    state_nxt = fetch_start ? REQ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    im_req   = (state == REQ);
    ir_valid = (state == DONE);
    busy     = (state != IDLE);
  end

  // PC writes land only in IDLE or DONE so the address is frozen for a whole REQ.
  always_comb begin
    commit     = 1'b0;
    commit_val = npc;
    case (state)
      IDLE: commit = pc_wr;
      DONE: begin
        if (pc_wr) commit = 1'b1;
        else if (pend_valid) begin
          commit     = 1'b1;
          commit_val = pend_npc;
        end
      end
      default: commit = 1'b0;
    endcase
  end

`ifdef IFU_ALIGN_CHECK_EN
  assign commit_ok = commit && (commit_val[1:0] == 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    misalign <= 1'b0;
    else if (commit && (commit_val[1:0] != 2'b00)) misalign <= 1'b1;
  end
`else
  assign commit_ok = commit;
  assign misalign  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      ir         <= '0;
      pend_valid <= 1'b0;
      pend_npc   <= '0;
    end else begin
      if (commit_ok) pc <= commit_val;
      if (state == REQ && im_ack) ir <= im_rdata;
      if (state == REQ && pc_wr) begin
        pend_valid <= 1'b1;
        pend_npc   <= npc;
      end else if (state == DONE) begin
        pend_valid <= 1'b0;
      end
    end
  end

  assign npc_t   = pc + 32'd4;
  assign im_addr = {pc[31:2], 2'b00};

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch against a transaction-level model, plus pinned literal checks.
module tb_ifu_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fetch_start = 1'b0, pc_wr = 1'b0, im_ack = 1'b0;
  logic [31:0] npc = '0, im_rdata = '0;
  logic        im_req, ir_valid, busy, misalign;
  logic [31:0] im_addr, pc, npc_t, ir;

  ifu_fetch dut (
    .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .pc_wr(pc_wr), .npc(npc),
    .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack), .im_rdata(im_rdata),
    .pc(pc), .npc_t(npc_t), .ir(ir), .ir_valid(ir_valid), .busy(busy), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Model: what the fetch unit is doing in transaction terms.
  typedef enum int {M_IDLE, M_WAIT_ACK, M_DELIVER} phase_t;
  phase_t      m_phase;
  logic [31:0] m_pc, m_ir;
  logic        m_mis;
  logic [31:0] deferred[$];
  bit          chk_en = 1'b0;

  typedef struct { string name; int sel; logic [31:0] exp; } pin_t;
  pin_t pins[$];

  int total = 0;
  int bad = 0;

  function automatic void model_reset();
    m_phase = M_IDLE; m_pc = 32'h0000_3000; m_ir = '0; m_mis = 1'b0;
    deferred.delete();
  endfunction

  function automatic void model_commit(input logic [31:0] v);
`ifdef IFU_ALIGN_CHECK_EN
    if (v[1:0] != 2'b00) m_mis = 1'b1;
    else m_pc = v;
`else
    m_pc = v;
`endif
  endfunction

  function automatic void model_edge(input logic fs, input logic wr, input logic [31:0] n,
                                     input logic ack, input logic [31:0] rd);
    case (m_phase)
      M_IDLE: begin
        if (wr) model_commit(n);
        if (fs) m_phase = M_WAIT_ACK;
      end
      M_WAIT_ACK: begin
        if (wr) deferred.push_back(n);
        if (ack) begin m_ir = rd; m_phase = M_DELIVER; end
      end
      default: begin
        if (wr) model_commit(n);
        else if (deferred.size() > 0) model_commit(deferred[$]);
        deferred.delete();
        m_phase = fs ? M_WAIT_ACK : M_IDLE;
      end
    endcase
  endfunction

  function automatic logic [31:0] dut_out(input int sel);
    case (sel)
      0: return pc;
      1: return npc_t;
      2: return ir;
      3: return {31'd0, busy};
      4: return {31'd0, im_req};
      5: return im_addr;
      6: return {31'd0, ir_valid};
      default: return {31'd0, misalign};
    endcase
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endfunction

  // Single compare process: model check every cycle plus any pinned literals.
  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", pc, m_pc);
      check("npc_t", npc_t, m_pc + 32'd4);
      check("ir", ir, m_ir);
      check("busy", {31'd0, busy}, {31'd0, m_phase != M_IDLE});
      check("im_req", {31'd0, im_req}, {31'd0, m_phase == M_WAIT_ACK});
      check("im_addr", im_addr, m_pc & 32'hFFFF_FFFC);
      check("ir_valid", {31'd0, ir_valid}, {31'd0, m_phase == M_DELIVER});
      check("misalign", {31'd0, misalign}, {31'd0, m_mis});
    end
    while (pins.size() > 0) begin
      pin_t p;
      p = pins.pop_front();
      check(p.name, dut_out(p.sel), p.exp);
    end
  end

  task automatic pin(input string name, input int sel, input logic [31:0] exp);
    pin_t p;
    p.name = name; p.sel = sel; p.exp = exp;
    pins.push_back(p);
  endtask

  // Drive one cycle's inputs, let the edge happen, then advance the model.
  task automatic cyc(input logic fs, input logic wr, input logic [31:0] n,
                     input logic ack, input logic [31:0] rd);
    fetch_start = fs; pc_wr = wr; npc = n; im_ack = ack; im_rdata = rd;
    @(posedge clk);
    if (rst_n) model_edge(fs, wr, n, ack, rd);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Asynchronous reset between edges; held across one negedge, released before the next posedge.
  task automatic do_reset(input bit pin_it);
    rst_n = 1'b0;
    #1;
    model_reset();
    if (pin_it) begin
      pin("rst_pc", 0, 32'h0000_3000);
      pin("rst_npc_t", 1, 32'h0000_3004);
      pin("rst_ir", 2, 32'h0);
      pin("rst_busy", 3, 32'h0);
    end
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    do_reset(1'b1);
    chk_en = 1'b1;

    // zero-wait fetch
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    pin("zw_req", 4, 32'h1); pin("zw_addr", 5, 32'h0000_3000); pin("zw_irv0", 6, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h2008_0005);
    pin("zw_ir", 2, 32'h2008_0005); pin("zw_irv1", 6, 32'h1);
    idle();
    pin("zw_irv2", 6, 32'h0); pin("zw_hold", 2, 32'h2008_0005);

    // stalled fetch with a PC write deferred to DONE
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    idle();
    cyc(1'b0, 1'b1, 32'h0000_3010, 1'b0, 32'h0);
    pin("st_addr", 5, 32'h0000_3000); pin("st_pc", 0, 32'h0000_3000);
    idle();
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
    pin("st_addr2", 5, 32'h0000_3000); pin("st_irv", 6, 32'h1);
    idle();
    pin("st_pc2", 0, 32'h0000_3010); pin("st_busy", 3, 32'h0);

    // simultaneous start and write, then npc_t wrap
    cyc(1'b1, 1'b1, 32'h0000_3020, 1'b0, 32'h0);
    pin("sim_addr", 5, 32'h0000_3020);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hCAFE_0001);
    idle();
    cyc(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    pin("wrap_pc", 0, 32'hFFFF_FFFC); pin("wrap_npc_t", 1, 32'h0);

    // reset mid-fetch, then a stray ack
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    idle();
    do_reset(1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    pin("mid_req", 4, 32'h0); pin("mid_ir", 2, 32'h0); pin("mid_irv", 6, 32'h0);
    idle();
    pin("mid_irv2", 6, 32'h0);

    // misaligned write
    cyc(1'b0, 1'b1, 32'h0000_3002, 1'b0, 32'h0);
`ifdef IFU_ALIGN_CHECK_EN
    pin("mis_pc", 0, 32'h0000_3000); pin("mis_flag", 7, 32'h1);
`else
    pin("mis_pc", 0, 32'h0000_3002); pin("mis_flag", 7, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    pin("mis_addr", 5, 32'h0000_3000);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    idle();
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] n;
      n = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      if ($urandom_range(0, 3) == 0) n[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 199) == 0) do_reset(1'b0);
      cyc(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3), n,
          ($urandom_range(0, 9) < 4), $urandom());
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
